regfile_dump_unit: RTL and testbench
====================================

// Module: regfile_dump_unit
// PURPOSE
//  Post-halt register scan-out for the simple RISC CPU. Once the CPU asserts halted, walks register
//  indices 0..NUM_REGS-1 through a spare register-file read port and presents each value on out.
//  Each value is held for at least HOLD_CYCLES and moved on only with a valid/ready handshake.
//  Sits beside the CPU top, and out drives the board/bench-visible result bus. Optional continuous
//  (wrapping) mode supports repeated sampling.
// PARAMETERS
//  DATA_W      16  register/data width in bits (>=1)
//  NUM_REGS    8   registers scanned (>=2); IDX_W = $clog2(NUM_REGS)
//  READ_LAT    1   register-file read latency in cycles, 0..3 (0 = combinational read)
//  HOLD_CYCLES 13  minimum cycles each value stays valid before it may be accepted (>=1)
//  CONTINUOUS  0   1: wrap to index 0 after last reg; 0: single pass then DONE
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  halted     in   1       CPU halt status; level-sensitive start/abort
//  rd_idx     out  IDX_W   register index to regfile read port
//  rd_data    in   DATA_W  regfile data, valid READ_LAT cycles after rd_idx
//  out        out  DATA_W  presented register value
//  out_idx    out  IDX_W   index of value on out
//  out_valid  out  1       out/out_idx meaningful
//  out_ready  in   1       consumer accepts; transfer = out_valid & out_ready & hold elapsed
//  done       out  1       single-pass scan complete (CONTINUOUS=0 only)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; rd_idx=0, out=0, out_idx=0, out_valid=0, done=0, counters 0.
//  States: IDLE -> READ -> PRESENT -> (READ | DONE); all registered.
//  IDLE: outputs cleared; on halted=1 -> READ with idx=0.
//  READ: drive rd_idx=idx; wait READ_LAT cycles (lat counter); on the cycle rd_data valid, capture
//    out<=rd_data, out_idx<=idx, out_valid<=1, hold counter<=0 -> PRESENT. READ_LAT=0 captures the
//    same cycle READ is entered, so READ lasts exactly 1 cycle for any READ_LAT 0 or 1; READ_LAT=n>=1
//    lasts n cycles.
//  PRESENT: hold counter increments to saturation at HOLD_CYCLES-1. Accept when counter reached
//    HOLD_CYCLES-1 AND out_ready=1 (ready before hold elapses is ignored). On accept: out_valid<=0;
//    if idx==NUM_REGS-1: CONTINUOUS ? idx<=0, READ : DONE; else idx<=idx+1, READ.
//  out stays stable (never changes) while out_valid=1; no new capture until accept.
//  Per-register minimum period with out_ready tied 1 = READ_LAT(min 1) + HOLD_CYCLES cycles.
//  DONE: done=1, out_valid=0, out retains last value; stays until halted=0 -> IDLE.
//  Abort: halted=0 in any non-IDLE state -> IDLE next cycle, outputs cleared as reset (done=0).
//  halted re-asserted after abort restarts at idx 0; halted held high in DONE does not restart.
//  Index wrap uses explicit compare with NUM_REGS-1 (NUM_REGS need not be a power of 2).
//  No arithmetic on data; out is rd_data bit-exact, DATA_W wide.
// STRUCTURE
//  Shared package cpu_pkg: state enum dump_state_t {IDLE,READ,PRESENT,DONE}; DATA_W default
//  constant shared with the CPU datapath.
//  Single sub-module: sat_counter (parametrised width/limit, clear, enable, at_limit flag), used for
//  both latency and hold counters. Remainder is one always_ff FSM plus output registers.
// TESTING
//  1 Defaults, regs r0..r7=8'h0A+i, out_ready=1, halted rises at t0 -> out_valid pulses 8 values
//    0x000A..0x0011, idx 0..7, each valid exactly 13 cycles, 1-cycle gaps; then done=1 and stays.
//  2 out_ready low during hold, raised on cycle 20 of reg 3 -> reg 3 held 20+ cycles, out unchanged;
//    reg 4 follows; ready pulses before cycle 13 produce no accept.
//  3 halted dropped while presenting reg 5 -> next cycle out_valid=0, out=0, done=0; halted
//    re-raised -> scan restarts at idx 0.
//  4 CONTINUOUS=1, NUM_REGS=5, HOLD=2 -> idx sequence 0,1,2,3,4,0,1,... done never asserts.
//  5 READ_LAT=0 and READ_LAT=3 with DATA_W=32, value 32'hDEAD_BEEF in r2 -> captured exactly; period
//    per reg = 1+HOLD and 3+HOLD.
//  6 rst_n asserted mid-PRESENT (async, between edges) -> outputs zero immediately; scan restarts at
//    idx 0 after release if halted=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, dump-unit state encoding and a
// helper for sizing small counters.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } dump_state_t;

  // Bits needed to count 0..limit; never less than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at LIMIT; clear has priority over enable and
// at_limit flags the saturated value.
module sat_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIM)) begin
      count <= count + W'(1);
    end
  end

  assign at_limit = (count == LIM);

endmodule

// File: rtl/regfile_dump_unit.sv
// Post-halt register scan-out: walks every register through a spare
// regfile read port and presents each value with a minimum hold time.
//
// state   | meaning
// IDLE    | CPU running; outputs cleared, waiting for halted
// READ    | rd_idx issued, waiting for regfile read latency
// PRESENT | value on out, hold timer running, waiting for accept
// DONE    | single pass finished; done high until halted drops
module regfile_dump_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W      = CPU_DATA_W,
  parameter int NUM_REGS    = 8,
  parameter int READ_LAT    = 1,
  parameter int HOLD_CYCLES = 13,
  parameter int CONTINUOUS  = 0,
  parameter int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  localparam int LAT_LIMIT  = (READ_LAT < 1) ? 0 : READ_LAT - 1;
  localparam int HOLD_LIMIT = HOLD_CYCLES - 1;
  localparam int LAT_W      = cnt_width(LAT_LIMIT);
  localparam int HOLD_W     = cnt_width(HOLD_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  dump_state_t       state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [IDX_W-1:0]  rd_ptr, rd_ptr_d;
  logic [DATA_W-1:0] out_d;
  logic [IDX_W-1:0]  out_idx_d;
  logic              out_valid_d;
  logic              done_d;
  logic              lat_done;
  logic              hold_done;

  sat_counter #(
    .W     (LAT_W),
    .LIMIT (LAT_LIMIT)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != READ),
    .enable   (1'b1),
    .at_limit (lat_done)
  );

  sat_counter #(
    .W     (HOLD_W),
    .LIMIT (HOLD_LIMIT)
  ) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != PRESENT),
    .enable   (1'b1),
    .at_limit (hold_done)
  );

  // rd_ptr runs one register ahead of the capture so that a one-cycle
  // latency port already has the next value ready when READ is entered.
  assign rd_idx = rd_ptr;

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    rd_ptr_d    = rd_ptr;
    out_d       = out;
    out_idx_d   = out_idx;
    out_valid_d = out_valid;
    done_d      = done;

    if ((state != IDLE) && !halted) begin
      state_d     = IDLE;
      idx_d       = '0;
      rd_ptr_d    = '0;
      out_d       = '0;
      out_idx_d   = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx_d       = '0;
          rd_ptr_d    = '0;
          out_d       = '0;
          out_idx_d   = '0;
          out_valid_d = 1'b0;
          done_d      = 1'b0;
          if (halted) begin
            state_d = READ;
          end
        end

        READ: begin
          if (lat_done) begin
            out_d       = rd_data;
            out_idx_d   = idx;
            out_valid_d = 1'b1;
            rd_ptr_d    = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            state_d     = PRESENT;
          end
        end

        PRESENT: begin
          if (hold_done && out_ready) begin
            out_valid_d = 1'b0;
            if (idx == LAST_IDX) begin
              if (CONTINUOUS != 0) begin
                idx_d   = '0;
                state_d = READ;
              end else begin
                done_d  = 1'b1;
                state_d = DONE;
              end
            end else begin
              idx_d   = idx + IDX_W'(1);
              state_d = READ;
            end
          end
        end

        DONE: begin
          done_d      = 1'b1;
          out_valid_d = 1'b0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      rd_ptr    <= '0;
      out       <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      rd_ptr    <= rd_ptr_d;
      out       <= out_d;
      out_idx   <= out_idx_d;
      out_valid <= out_valid_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: default single pass, back-pressure,
// abort/restart, async reset, continuous wrap and read latencies 0 and 3.
module tb_regfile_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   w;

  // A: defaults (16-bit, 8 regs, latency 1, hold 13, single pass)
  logic        halted_a, out_ready_a, out_valid_a, done_a;
  logic [2:0]  rd_idx_a, out_idx_a;
  logic [15:0] rd_data_a, out_a;
  logic [15:0] mem_a [8];

  // B: continuous, 5 regs, hold 2
  logic        halted_b, out_ready_b, out_valid_b, done_b;
  logic [2:0]  rd_idx_b, out_idx_b;
  logic [15:0] rd_data_b, out_b;
  logic [15:0] mem_b [8];

  // C: 32-bit, latency 0, hold 4
  logic        halted_c, out_ready_c, out_valid_c, done_c;
  logic [2:0]  rd_idx_c, out_idx_c;
  logic [31:0] rd_data_c, out_c;
  logic [31:0] mem_c [8];

  // D: 32-bit, latency 3, hold 4
  logic        halted_d, out_ready_d, out_valid_d, done_d;
  logic [2:0]  rd_idx_d, out_idx_d;
  logic [31:0] rd_data_d, out_d, d_p1, d_p2;
  logic [31:0] mem_d [8];

  always @(posedge clk) rd_data_a <= mem_a[rd_idx_a];
  always @(posedge clk) rd_data_b <= mem_b[rd_idx_b];
  assign rd_data_c = mem_c[rd_idx_c];
  always @(posedge clk) begin
    d_p1      <= mem_d[rd_idx_d];
    d_p2      <= d_p1;
    rd_data_d <= d_p2;
  end

  regfile_dump_unit u_dut_a (
    .clk(clk), .rst_n(rst_n), .halted(halted_a), .rd_idx(rd_idx_a), .rd_data(rd_data_a),
    .out(out_a), .out_idx(out_idx_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .done(done_a)
  );

  regfile_dump_unit #(.NUM_REGS(5), .HOLD_CYCLES(2), .CONTINUOUS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .halted(halted_b), .rd_idx(rd_idx_b), .rd_data(rd_data_b),
    .out(out_b), .out_idx(out_idx_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .done(done_b)
  );

  regfile_dump_unit #(.DATA_W(32), .READ_LAT(0), .HOLD_CYCLES(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .halted(halted_c), .rd_idx(rd_idx_c), .rd_data(rd_data_c),
    .out(out_c), .out_idx(out_idx_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .done(done_c)
  );

  regfile_dump_unit #(.DATA_W(32), .READ_LAT(3), .HOLD_CYCLES(4)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .halted(halted_d), .rd_idx(rd_idx_d), .rd_data(rd_data_d),
    .out(out_d), .out_idx(out_idx_d), .out_valid(out_valid_d), .out_ready(out_ready_d),
    .done(done_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Waits for the next value on A, then drives out_ready per ready_at/pulse_at
  // (cycle numbers within the valid window, 1-based) and measures the window.
  task automatic take_a(input int exp_idx, input logic [15:0] exp_val, input int ready_at,
                        input int pulse_at, input int exp_len, input int exp_gap);
    int wt;
    int c;
    wt = 0;
    c  = 1;
    out_ready_a = (ready_at <= 0);
    while (!out_valid_a && wt < 30) begin
      cyc();
      wt++;
    end
    chk("a_gap", wt, exp_gap);
    chk("a_idx", 32'(out_idx_a), exp_idx);
    chk("a_val", 32'(out_a), 32'(exp_val));
    while (out_valid_a && c < 60) begin
      out_ready_a = (c >= ready_at) || (c == pulse_at);
      cyc();
      if (out_valid_a) begin
        chk("a_hold_stable", 32'(out_a), 32'(exp_val));
        c++;
      end
    end
    chk("a_valid_len", c, exp_len);
  endtask

  int pv_b, pv_c, pv_d;
  int rise_b, rise_c, rise_d;
  int last_b, last_c, last_d;

  initial begin
    rst_n = 1'b1;
    halted_a = 1'b0; halted_b = 1'b0; halted_c = 1'b0; halted_d = 1'b0;
    out_ready_a = 1'b0; out_ready_b = 1'b1; out_ready_c = 1'b1; out_ready_d = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 16'(10 + i);
      mem_b[i] = 16'(256 + i);
      mem_c[i] = 32'h1000_0000 + 32'(i);
      mem_d[i] = 32'h2000_0000 + 32'(i);
    end
    mem_c[2] = 32'hDEAD_BEEF;
    mem_d[2] = 32'hDEAD_BEEF;

    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("rst_out", 32'(out_a), 32'd0);
    chk("rst_out_idx", 32'(out_idx_a), 32'd0);
    chk("rst_rd_idx", 32'(rd_idx_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);

    // Single pass with ready tied high.
    halted_a = 1'b1;
    for (int r = 0; r < 8; r++) take_a(r, 16'(10 + r), 0, 0, 13, (r == 0) ? 2 : 1);
    for (int k = 0; k < 5; k++) begin
      chk("done_high", 32'(done_a), 32'd1);
      chk("done_valid_low", 32'(out_valid_a), 32'd0);
      chk("done_out_kept", 32'(out_a), 32'h11);
      cyc();
    end

    // Leave DONE, restart, then back-pressure on regs 3 and 4.
    halted_a = 1'b0;
    cyc();
    chk("exit_done", 32'(done_a), 32'd0);
    chk("exit_out", 32'(out_a), 32'd0);
    halted_a = 1'b1;
    take_a(0, 16'h0A, 13, 0, 13, 2);
    take_a(1, 16'h0B, 13, 0, 13, 1);
    take_a(2, 16'h0C, 13, 0, 13, 1);
    take_a(3, 16'h0D, 20, 5, 20, 1);
    take_a(4, 16'h0E, 13, 7, 13, 1);

    // Abort while presenting reg 5.
    out_ready_a = 1'b0;
    w = 0;
    while (!out_valid_a && w < 30) begin cyc(); w++; end
    chk("abort_pre_idx", 32'(out_idx_a), 32'd5);
    repeat (4) cyc();
    halted_a = 1'b0;
    cyc();
    chk("abort_valid", 32'(out_valid_a), 32'd0);
    chk("abort_out", 32'(out_a), 32'd0);
    chk("abort_out_idx", 32'(out_idx_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_rd_idx", 32'(rd_idx_a), 32'd0);
    halted_a = 1'b1;
    take_a(0, 16'h0A, 13, 0, 13, 2);
    take_a(1, 16'h0B, 13, 0, 13, 1);

    // Async reset between edges while presenting reg 2.
    out_ready_a = 1'b0;
    w = 0;
    while (!out_valid_a && w < 30) begin cyc(); w++; end
    chk("arst_pre_idx", 32'(out_idx_a), 32'd2);
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_a), 32'd0);
    chk("arst_out", 32'(out_a), 32'd0);
    chk("arst_out_idx", 32'(out_idx_a), 32'd0);
    cyc();
    rst_n = 1'b1;
    take_a(0, 16'h0A, 13, 0, 13, 2);
    halted_a = 1'b0;
    cyc();

    // Continuous wrap (B) and read latencies 0 / 3 (C, D) side by side.
    pv_b = 0; pv_c = 0; pv_d = 0;
    rise_b = 0; rise_c = 0; rise_d = 0;
    last_b = 0; last_c = 0; last_d = 0;
    halted_b = 1'b1; halted_c = 1'b1; halted_d = 1'b1;
    for (int cy = 1; cy <= 70; cy++) begin
      cyc();
      if (out_valid_b && pv_b == 0) begin
        chk("b_idx", 32'(out_idx_b), rise_b % 5);
        chk("b_val", 32'(out_b), 32'h100 + 32'(rise_b % 5));
        if (rise_b > 0) chk("b_period", cy - last_b, 3);
        last_b = cy;
        rise_b++;
      end
      chk("b_done_low", 32'(done_b), 32'd0);
      pv_b = int'(out_valid_b);
      if (out_valid_c && pv_c == 0) begin
        chk("c_idx", 32'(out_idx_c), rise_c);
        chk("c_val", out_c, mem_c[rise_c[2:0]]);
        if (rise_c > 0) chk("c_period", cy - last_c, 5);
        last_c = cy;
        rise_c++;
      end
      pv_c = int'(out_valid_c);
      if (out_valid_d && pv_d == 0) begin
        chk("d_idx", 32'(out_idx_d), rise_d);
        chk("d_val", out_d, mem_d[rise_d[2:0]]);
        if (rise_d > 0) chk("d_period", cy - last_d, 7);
        last_d = cy;
        rise_d++;
      end
      pv_d = int'(out_valid_d);
    end
    chk("b_rises", rise_b, 23);
    chk("c_rises", rise_c, 8);
    chk("d_rises", rise_d, 8);
    chk("c_first_rise_seen_d_last", last_d, 53);
    chk("c_done", 32'(done_c), 32'd1);
    chk("d_done", 32'(done_d), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
